// File: rtl/dmem_responder.sv
// Multi-cycle RV64 data-memory responder: valid/ready request, fixed-latency one-cycle response.
// Define DMEM_ERR_EN to fault misaligned/out-of-range accesses; otherwise addresses wrap and misaligned offsets are aligned down.
module dmem_responder #(
  parameter int DEPTH_WORDS = 512,
  parameter int LAT         = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic        ready_reg, rsp_valid_reg, rsp_err_reg;
  logic        cap_we, cap_unsigned;
  logic [63:0] cap_addr, cap_wdata;
  logic [1:0]  cap_size;

  logic [63:0] mem [DEPTH_WORDS];
  logic [63:0] rd_word_reg;

  // The access fields come straight from the port when the array is touched on the accept edge (LAT=0).
  logic        in_idle, a_we, a_unsigned, a_err, access_en, addr_unused;
  logic [63:0] a_addr, a_wdata, wdata_sh, rd_shift, load_data;
  logic [1:0]  a_size;
  logic [2:0]  size_mask, a_off;
  logic [3:0]  nbytes;
  logic [AW-1:0] a_idx;
  logic [7:0]  lane_en;

  assign in_idle    = (state_reg == IDLE);
  assign a_we       = in_idle ? req_we       : cap_we;
  assign a_addr     = in_idle ? req_addr     : cap_addr;
  assign a_wdata    = in_idle ? req_wdata    : cap_wdata;
  assign a_size     = in_idle ? req_size     : cap_size;
  assign a_unsigned = in_idle ? req_unsigned : cap_unsigned;

  always_comb begin
    case (a_size)
      2'd0:    size_mask = 3'd0;
      2'd1:    size_mask = 3'd1;
      2'd2:    size_mask = 3'd3;
      default: size_mask = 3'd7;
    endcase
  end

  assign nbytes      = {1'b0, size_mask} + 4'd1;
  assign a_idx       = a_addr[3 +: AW];
  assign addr_unused = ^a_addr[63:3+AW];

`ifdef DMEM_ERR_EN
  assign a_off = a_addr[2:0];
  assign a_err = ((a_addr[2:0] & size_mask) != 3'd0) || (a_addr >= 64'(DEPTH_WORDS * 8));
`else
  assign a_off = a_addr[2:0] & ~size_mask;
  assign a_err = 1'b0;
`endif

  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    assign lane_en[gi] = ({1'b0, a_off} <= 4'(gi)) && (4'(gi) < ({1'b0, a_off} + nbytes));
  end

  assign wdata_sh  = a_wdata << {a_off, 3'b000};
  assign access_en = (in_idle && req_valid && (LAT == 0)) ||
                     ((state_reg == BUSY) && (cnt_reg == 4'd1));

  // Stores commit and loads sample on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (access_en) begin
      rd_word_reg <= mem[a_idx];
      if (a_we && !a_err) begin
        for (int i = 0; i < 8; i++) begin
          if (lane_en[i]) mem[a_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_shift = rd_word_reg >> {a_off, 3'b000};
    case (a_size)
      2'd0:    load_data = a_unsigned ? {56'd0, rd_shift[7:0]}  : {{56{rd_shift[7]}},  rd_shift[7:0]};
      2'd1:    load_data = a_unsigned ? {48'd0, rd_shift[15:0]} : {{48{rd_shift[15]}}, rd_shift[15:0]};
      2'd2:    load_data = a_unsigned ? {32'd0, rd_shift[31:0]} : {{32{rd_shift[31]}}, rd_shift[31:0]};
      default: load_data = rd_shift;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      ready_reg     <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      cap_we        <= 1'b0;
      cap_unsigned  <= 1'b0;
      cap_addr      <= 64'd0;
      cap_wdata     <= 64'd0;
      cap_size      <= 2'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            cap_we       <= req_we;
            cap_unsigned <= req_unsigned;
            cap_addr     <= req_addr;
            cap_wdata    <= req_wdata;
            cap_size     <= req_size;
            ready_reg    <= 1'b0;
            if (LAT == 0) begin
              state_reg     <= RESP;
              rsp_valid_reg <= 1'b1;
              rsp_err_reg   <= a_err;
            end else begin
              state_reg <= BUSY;
              cnt_reg   <= 4'(LAT);
            end
          end
        end
        BUSY: begin
          cnt_reg <= cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) begin
            state_reg     <= RESP;
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= a_err;
          end
        end
        RESP: begin
          state_reg     <= IDLE;
          rsp_valid_reg <= 1'b0;
          rsp_err_reg   <= 1'b0;
          ready_reg     <= 1'b1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready = ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_rdata = (rsp_valid_reg && !a_we && !rsp_err_reg) ? load_data : 64'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LAT=2 instance for directed/random traffic, LAT=0 instance for a back-to-back burst.
module tb_dmem_responder;
  localparam int DW  = 512;
  localparam int LAT = 2;
  localparam int NB  = DW * 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_we, req_unsigned, rsp_valid, rsp_err;
  logic [63:0] req_addr, req_wdata, rsp_rdata;
  logic [1:0]  req_size;
  logic        z_req_valid, z_req_ready, z_req_we, z_req_unsigned, z_rsp_valid, z_rsp_err;
  logic [63:0] z_req_addr, z_req_wdata, z_rsp_rdata;
  logic [1:0]  z_req_size;

  dmem_responder #(.DEPTH_WORDS(DW), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

  dmem_responder #(.DEPTH_WORDS(DW), .LAT(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_size(z_req_size), .req_unsigned(z_req_unsigned),
    .rsp_valid(z_rsp_valid), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err));

  int passes = 0;
  int fails  = 0;
  int checks = 0;

  // Byte-addressed reference memories, one per instance.
  logic [7:0] mm [2][NB];

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model(input int inst, input logic we, input logic [63:0] addr,
                                input logic [63:0] wdata, input logic [1:0] size, input logic uns,
                                output logic [63:0] rdata, output logic err);
    int n;
    longint unsigned a;
    logic [63:0] v;
    n = 1 << size;
    rdata = 64'd0;
    err = 1'b0;
`ifdef DMEM_ERR_EN
    if ((addr % n) != 0 || addr >= NB) begin
      err = 1'b1;
      return;
    end
    a = addr;
`else
    a = addr % NB;
    a = a - (a % n);
`endif
    if (we) begin
      for (int i = 0; i < n; i++) mm[inst][int'(a) + i] = wdata[8*i +: 8];
    end else begin
      v = 64'd0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = mm[inst][int'(a) + i];
      if (!uns && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
      rdata = v;
    end
  endfunction

  task automatic do_req(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [1:0] size, input logic uns, input string tag,
                        output logic [63:0] got, output logic gerr);
    logic [63:0] er;
    logic ee;
    int k;
    @(negedge clk);
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check64({tag, " ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    req_size = size; req_unsigned = uns;
    model(0, we, addr, wdata, size, uns, er, ee);
    @(posedge clk);
    #1 req_valid = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!rsp_valid && k < 20);
    got = rsp_rdata;
    gerr = rsp_err;
    check64({tag, " lat"}, 64'(k), 64'(LAT + 1));
    check64({tag, " rdata"}, rsp_rdata, er);
    check64({tag, " err"}, 64'(rsp_err), 64'(ee));
    @(negedge clk);
    check64({tag, " pulse"}, 64'(rsp_valid), 64'd0);
    check64({tag, " ready back"}, 64'(req_ready), 64'd1);
    $display("%s: we=%0d addr=%h size=%0d uns=%0d rdata=%h err=%0d", tag, we, addr, size, uns, got, gerr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] g, prior, ra;
    logic ge, seen;
    logic        b_we [10];
    logic [63:0] b_addr [10];
    logic [63:0] b_wdata [10];
    logic [1:0]  b_size [10];
    logic        b_uns [10];
    logic [63:0] q_rdata [$];
    logic        q_err [$];
    int          q_cyc [$];
    logic [63:0] er;
    logic        ee;
    int n_acc, last_acc, cyc, n;

    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_size = '0; req_unsigned = 1'b0;
    z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_req_size = '0; z_req_unsigned = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check64("reset ready", 64'(req_ready), 64'd1);
    check64("reset rsp_valid", 64'(rsp_valid), 64'd0);
    check64("reset rdata", rsp_rdata, 64'd0);
    check64("reset err", 64'(rsp_err), 64'd0);
    check64("reset ready lat0", 64'(z_req_ready), 64'd1);

    for (int w = 0; w < 16; w++)
      do_req(1'b1, 64'(w * 8), {$urandom(), $urandom()}, 2'd3, 1'b0, "init", g, ge);

    do_req(1'b1, 64'h40, 64'h1122334455667788, 2'd3, 1'b0, "sd40", g, ge);
    do_req(1'b0, 64'h40, 64'd0, 2'd3, 1'b0, "ld40", g, ge);
    check64("ld40 const", g, 64'h1122334455667788);
    do_req(1'b1, 64'h43, 64'hAB, 2'd0, 1'b0, "sb43", g, ge);
    do_req(1'b0, 64'h43, 64'd0, 2'd0, 1'b1, "lbu43", g, ge);
    check64("lbu43 const", g, 64'h00000000000000AB);
    do_req(1'b0, 64'h43, 64'd0, 2'd0, 1'b0, "lb43", g, ge);
    check64("lb43 const", g, 64'hFFFFFFFFFFFFFFAB);
    do_req(1'b0, 64'h40, 64'd0, 2'd3, 1'b0, "ld40b", g, ge);
    check64("ld40b const", g, 64'h11223344AB667788);
    do_req(1'b1, 64'h44, 64'h80000000, 2'd2, 1'b0, "sw44", g, ge);
    do_req(1'b0, 64'h44, 64'd0, 2'd2, 1'b0, "lw44", g, ge);
    check64("lw44 const", g, 64'hFFFFFFFF80000000);
    do_req(1'b0, 64'h44, 64'd0, 2'd2, 1'b1, "lwu44", g, ge);
    check64("lwu44 const", g, 64'h0000000080000000);
    do_req(1'b1, 64'h41, 64'hBEEF, 2'd1, 1'b0, "sh41", g, ge);
`ifdef DMEM_ERR_EN
    check64("sh41 err const", 64'(ge), 64'd1);
`endif
    do_req(1'b0, 64'h40, 64'd0, 2'd3, 1'b0, "ld40c", g, ge);
`ifdef DMEM_ERR_EN
    check64("ld40c const", g, 64'h80000000AB667788);
`else
    check64("ld40c const", g, 64'h80000000AB66BEEF);
`endif
    do_req(1'b0, 64'(NB), 64'd0, 2'd3, 1'b0, "ld oor", g, ge);
`ifdef DMEM_ERR_EN
    check64("ld oor err const", 64'(ge), 64'd1);
    check64("ld oor rdata const", g, 64'd0);
`endif

    // Reset during BUSY must drop the pending store.
    prior = {$urandom(), $urandom()};
    do_req(1'b1, 64'h80, prior, 2'd3, 1'b0, "sd80", g, ge);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h80; req_wdata = '1; req_size = 2'd3; req_unsigned = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check64("rst ready", 64'(req_ready), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    check64("rst no rsp", 64'(seen), 64'd0);
    $display("reset during BUSY: rsp seen=%0d", seen);
    do_req(1'b0, 64'h80, 64'd0, 2'd3, 1'b0, "ld80", g, ge);
    check64("ld80 prior", g, prior);

    for (int t = 0; t < 60; t++) begin
      logic [1:0] sz;
      sz = 2'($urandom_range(0, 3));
      n = 1 << sz;
      ra = 64'($urandom_range(0, 127));
      if ($urandom_range(0, 3) != 0) ra = ra & ~64'(n - 1);
      if ($urandom_range(0, 7) == 0) ra = ra + 64'(NB * $urandom_range(1, 3));
      do_req(1'($urandom_range(0, 1)), ra, {$urandom(), $urandom()}, sz, 1'($urandom_range(0, 1)),
             "rand", g, ge);
    end

    // LAT=0 burst with req_valid held high.
    for (int i = 0; i < 10; i++) begin
      if (i < 5) begin
        b_we[i] = 1'b1; b_addr[i] = 64'(i * 8); b_size[i] = 2'd3; b_uns[i] = 1'b0;
        b_wdata[i] = {$urandom(), $urandom()};
      end else begin
        b_we[i] = 1'b0; b_size[i] = 2'($urandom_range(0, 3)); b_uns[i] = 1'($urandom_range(0, 1));
        b_addr[i] = 64'($urandom_range(0, 39)) & ~64'((1 << b_size[i]) - 1);
        b_wdata[i] = 64'd0;
      end
    end
    n_acc = 0; last_acc = 0; cyc = 0;
    while (cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (z_rsp_valid) begin
        if (q_rdata.size() == 0) begin
          check64("b2b extra rsp", 64'(z_rsp_valid), 64'd0);
        end else begin
          check64("b2b rsp cycle", 64'(cyc), 64'(q_cyc.pop_front() + 1));
          check64("b2b rdata", z_rsp_rdata, q_rdata.pop_front());
          check64("b2b err", 64'(z_rsp_err), 64'(q_err.pop_front()));
          $display("b2b rsp: cyc=%0d rdata=%h err=%0d", cyc, z_rsp_rdata, z_rsp_err);
        end
      end
      if (n_acc < 10) begin
        z_req_valid = 1'b1; z_req_we = b_we[n_acc]; z_req_addr = b_addr[n_acc];
        z_req_wdata = b_wdata[n_acc]; z_req_size = b_size[n_acc]; z_req_unsigned = b_uns[n_acc];
        if (z_req_ready) begin
          if (n_acc > 0) check64("b2b accept spacing", 64'(cyc - last_acc), 64'd2);
          model(1, b_we[n_acc], b_addr[n_acc], b_wdata[n_acc], b_size[n_acc], b_uns[n_acc], er, ee);
          q_rdata.push_back(er); q_err.push_back(ee); q_cyc.push_back(cyc);
          last_acc = cyc;
          n_acc++;
        end
      end else begin
        z_req_valid = 1'b0;
      end
    end
    check64("b2b accepts", 64'(n_acc), 64'd10);
    check64("b2b pending", 64'(q_rdata.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
